// File: rtl/usr_serial_deser.sv
// Serial frame receiver: start bit, WIDTH data bits, even-parity bit; the decoded word
// is held on a valid/ready output until the consumer takes it.
module usr_serial_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sdin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             par_err,
    output logic             ovf,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             par_err_q, par_err_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    bit_idx;
    logic             load_edge;
    logic             slot_free;

    assign bit_idx = MSB_FIRST ? (CNT_LAST - cnt_q) : cnt_q;

    // Frame FSM; en=0 edges leave state, counter and shift register untouched.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        load_edge = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (sdin) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    sreg_d[bit_idx] = sdin;
                    if (cnt_q == CNT_LAST) state_d = S_PARITY;
                    else                   cnt_d   = cnt_q + CW'(1);
                end
                S_PARITY: begin
                    load_edge = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The holding slot frees up on the same edge the consumer takes the old word.
    always_comb begin
        slot_free    = !dout_valid_q || dout_ready;
        dout_d       = dout_q;
        par_err_d    = par_err_q;
        dout_valid_d = dout_valid_q;
        ovf_d        = 1'b0;
        if (load_edge && slot_free) begin
            dout_d       = sreg_q;
            par_err_d    = ^sreg_q ^ sdin;
            dout_valid_d = 1'b1;
        end else begin
            if (load_edge)                  ovf_d        = 1'b1;
            if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            par_err_q    <= par_err_d;
            ovf_q        <= ovf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign par_err    = par_err_q;
    assign ovf        = ovf_q;
    assign busy       = (state_q == S_DATA) || (state_q == S_PARITY);
    assign state_dbg  = state_q;
endmodule
